// File: rtl/af4_ipoh_pkg.sv
// Shared encodings and constants for the af4_ipoh 8-port round-robin arbiter.
// The optional grant-hold timeout is enabled by defining AF4_IPOH_ARB8_TMO_EN.
package af4_ipoh_pkg;
   localparam int NPORT = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic [NPORT-1:0] grant;
      logic [IDX_W-1:0] id;
      logic             vld;
   } gnt_t;

   function automatic logic [NPORT-1:0] idx2oh(input logic [IDX_W-1:0] idx);
      idx2oh      = '0;
      idx2oh[idx] = 1'b1;
   endfunction
endpackage

// File: rtl/af4_ipoh_vote8.sv
// Rotating-priority winner search: first set req bit at prior, prior+1, ... with wrap.
module af4_ipoh_vote8
   import af4_ipoh_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [IDX_W-1:0] prior,
   output logic [IDX_W-1:0] win,
   output logic             winval
);
   logic [NPORT-1:0] rot;
   logic [IDX_W-1:0] idx;

   // rot[i] is the request of the port i places after prior.
   always_comb begin
      rot    = '0;
      idx    = '0;
      win    = '0;
      winval = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         idx    = prior + IDX_W'(i);
         rot[i] = req[idx];
      end
      for (int i = NPORT-1; i >= 0; i--) begin
         if (rot[i]) begin
            win    = prior + IDX_W'(i);
            winval = 1'b1;
         end
      end
   end
endmodule

// File: rtl/af4_ipoh_arb8.sv
// 8-port round-robin arbiter with registered one-hot grant and done/abort release.
// Define AF4_IPOH_ARB8_TMO_EN to add the TOMAX-cycle grant-hold timeout.
module af4_ipoh_arb8
   import af4_ipoh_pkg::*;
#(
   parameter int unsigned TOMAX = 8'd255,
   parameter int unsigned TOW   = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [NPORT-1:0] req,
   input  logic             done,
   output logic [NPORT-1:0] grant,
   output logic [IDX_W-1:0] gnt_id,
   output logic             gnt_vld,
   output logic             tmo
);
   if (TOMAX >= (64'd1 << TOW)) begin : g_bad_tomax
      $error("TOMAX does not fit in TOW bits");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] prior_q, prior_d;
   gnt_t             gnt_q, gnt_d;
   logic             tmo_q, tmo_d;
   logic [IDX_W-1:0] win;
   logic             winval;
   logic             usr_rel, to_hit, rel;

   af4_ipoh_vote8 u_vote (
      .req    (req),
      .prior  (prior_q),
      .win    (win),
      .winval (winval)
   );

   assign usr_rel = (state_q == ST_GRANT) && (done || !req[gnt_q.id]);
   assign rel     = usr_rel || to_hit;

`ifdef AF4_IPOH_ARB8_TMO_EN
   localparam logic [TOW-1:0] TO_LAST = TOW'(TOMAX - 1);
   logic [TOW-1:0] cnt_q, cnt_d;

   assign to_hit = (state_q == ST_GRANT) && (cnt_q == TO_LAST);
   // A holder's own done/abort wins over the timeout, so no tmo then.
   assign tmo_d  = to_hit && !usr_rel;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == ST_IDLE || rel) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign to_hit = 1'b0;
   assign tmo_d  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prior_q <= '0;
         gnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         prior_q <= prior_d;
         gnt_q   <= gnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (winval) state_d = ST_GRANT;
         ST_GRANT: if (rel)    state_d = ST_IDLE;
         default:              state_d = ST_IDLE;
      endcase
   end

   // Released holder drops to lowest priority by moving prior just past it.
   always_comb begin
      prior_d = prior_q;
      gnt_d   = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (winval) begin
               gnt_d.grant = idx2oh(win);
               gnt_d.id    = win;
               gnt_d.vld   = 1'b1;
            end
         end
         ST_GRANT: begin
            if (rel) begin
               gnt_d   = '0;
               prior_d = gnt_q.id + 1'b1;
            end
         end
         default: gnt_d = '0;
      endcase
   end

   assign grant   = gnt_q.grant;
   assign gnt_id  = gnt_q.id;
   assign gnt_vld = gnt_q.vld;
   assign tmo     = tmo_q;
endmodule

// File: tb/tb_af4_ipoh_arb8.sv
// Self-checking bench for af4_ipoh_arb8: directed scenarios plus random traffic vs a model.
module tb_af4_ipoh_arb8;
   localparam int TB_TOMAX = 4;
`ifdef AF4_IPOH_ARB8_TMO_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic [2:0] gnt_id;
   logic       gnt_vld, tmo;
   logic [12:0] obs;

   int n_chk = 0;
   int n_fail = 0;

   // Model: who holds the grant, how long, and who has top priority.
   bit m_vld, m_tmo;
   int m_id, m_prior, m_held;

   af4_ipoh_arb8 #(.TOMAX(TB_TOMAX), .TOW(8)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .tmo(tmo)
   );

   always #5 clk = ~clk;
   assign obs = {grant, gnt_id, gnt_vld, tmo};

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   function automatic logic [12:0] m_exp();
      logic [7:0] g;
      logic [2:0] id;
      g  = m_vld ? 8'(1 << m_id) : 8'h00;
      id = m_vld ? 3'(m_id) : 3'd0;
      return {g, id, m_vld, m_tmo};
   endfunction

   task automatic m_reset();
      m_vld = 0; m_tmo = 0; m_id = 0; m_prior = 0; m_held = 0;
   endtask

   task automatic m_release();
      m_prior = (m_id + 1) % 8;
      m_vld   = 0;
      m_id    = 0;
   endtask

   task automatic m_step(input logic [7:0] r, input logic d);
      m_tmo = 0;
      if (!m_vld) begin
         if (r != 0) begin
            m_id = pick(r, m_prior); m_vld = 1; m_held = 1;
         end
      end else if (d || !r[m_id]) begin
         m_release();
      end else if (TMO_ON && m_held >= TB_TOMAX) begin
         m_release(); m_tmo = 1;
      end else begin
         m_held++;
      end
   endtask

   // Called at a negedge: drive, clock once, return at the following negedge.
   task automatic step(input logic [7:0] r, input logic d);
      req = r; done = d;
      @(posedge clk);
      m_step(r, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 8'h00; done = 1'b0;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req = 8'hFF; done = 1'b0;
      #1;
      n_chk++;
      if (obs !== 13'h0) begin
         n_fail++; $display("FAIL reset_async: got %h expected %h", obs, 13'h0);
      end
      m_reset();
      @(negedge clk);
      req = 8'h00; rst = 1'b0;
      step(8'h00, 1'b0);
      n_chk++;
      if (obs !== m_exp()) begin
         n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, m_exp());
      end
   endtask

   task automatic test_basic();
      do_reset();
      step(8'h81, 1'b0);
      n_chk++;
      if (grant !== 8'h01 || gnt_id !== 3'd0 || gnt_vld !== 1'b1) begin
         n_fail++; $display("FAIL basic_first: got %h/%0d/%b expected 01/0/1", grant, gnt_id, gnt_vld);
      end
      step(8'h81, 1'b1);
      n_chk++;
      if (gnt_vld !== 1'b0 || grant !== 8'h00) begin
         n_fail++; $display("FAIL basic_release: got %b/%h expected 0/00", gnt_vld, grant);
      end
      step(8'h81, 1'b0);
      n_chk++;
      if (grant !== 8'h80 || gnt_id !== 3'd7) begin
         n_fail++; $display("FAIL basic_second: got %h/%0d expected 80/7", grant, gnt_id);
      end
      n_chk++;
      if (obs !== m_exp()) begin
         n_fail++; $display("FAIL basic_model: got %h expected %h", obs, m_exp());
      end
      step(8'h00, 1'b0);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int k = 0; k < 9; k++) begin
         step(8'hFF, 1'b0);
         n_chk++;
         if (gnt_vld !== 1'b1 || gnt_id !== 3'(k % 8)) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b/%0d expected 1/%0d", k, gnt_vld, gnt_id, k % 8);
         end
         step(8'hFF, 1'b1);
         n_chk++;
         if (gnt_vld !== 1'b0) begin
            n_fail++; $display("FAIL rr_gap[%0d]: got %b expected 0", k, gnt_vld);
         end
      end
      step(8'h00, 1'b0);
   endtask

   task automatic test_abort();
      do_reset();
      step(8'h08, 1'b0);
      n_chk++;
      if (gnt_id !== 3'd3 || gnt_vld !== 1'b1) begin
         n_fail++; $display("FAIL abort_grant: got %0d/%b expected 3/1", gnt_id, gnt_vld);
      end
      step(8'h00, 1'b0);
      n_chk++;
      if (gnt_vld !== 1'b0) begin
         n_fail++; $display("FAIL abort_drop: got %b expected 0", gnt_vld);
      end
      step(8'h00, 1'b1);
      n_chk++;
      if (obs !== 13'h0) begin
         n_fail++; $display("FAIL abort_idle_done: got %h expected %h", obs, 13'h0);
      end
      step(8'hFF, 1'b0);
      n_chk++;
      if (gnt_id !== 3'd4) begin
         n_fail++; $display("FAIL abort_prior: got %0d expected 4", gnt_id);
      end
      step(8'hFF, 1'b1);
      step(8'h00, 1'b0);
   endtask

   task automatic test_timeout();
      int hi;
      do_reset();
      step(8'h04, 1'b0);
      hi = 0;
`ifdef AF4_IPOH_ARB8_TMO_EN
      for (int i = 0; i < 20 && gnt_vld === 1'b1; i++) begin
         hi++;
         step(8'h04, 1'b0);
      end
      n_chk++;
      if (hi !== TB_TOMAX || tmo !== 1'b1 || gnt_vld !== 1'b0) begin
         n_fail++; $display("FAIL timeout_len: got %0d cycles tmo=%b expected %0d tmo=1", hi, tmo, TB_TOMAX);
      end
      step(8'hFF, 1'b0);
      n_chk++;
      if (gnt_id !== 3'd3 || tmo !== 1'b0) begin
         n_fail++; $display("FAIL timeout_prior: got %0d tmo=%b expected 3 tmo=0", gnt_id, tmo);
      end
      step(8'hFF, 1'b1);
`else
      for (int i = 0; i < 120; i++) begin
         if (gnt_vld === 1'b1 && gnt_id === 3'd2 && tmo === 1'b0) hi++;
         step(8'h04, 1'b0);
      end
      n_chk++;
      if (hi !== 120) begin
         n_fail++; $display("FAIL no_timeout_hold: got %0d cycles expected 120", hi);
      end
      step(8'h04, 1'b1);
`endif
      step(8'h00, 1'b0);
   endtask

   task automatic test_rst_mid();
      do_reset();
      step(8'hFF, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (obs !== 13'h0) begin
         n_fail++; $display("FAIL rst_mid: got %h expected %h", obs, 13'h0);
      end
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      step(8'h10, 1'b0);
      n_chk++;
      if (gnt_id !== 3'd4 || gnt_vld !== 1'b1) begin
         n_fail++; $display("FAIL rst_rearb: got %0d/%b expected 4/1", gnt_id, gnt_vld);
      end
      step(8'h10, 1'b1);
      step(8'h00, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       d;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         r = 8'($urandom) & 8'($urandom);
         if (m_vld && $urandom_range(0, 9) != 0) r[m_id] = 1'b1;
         d = ($urandom_range(0, 3) == 0);
         step(r, d);
         n_chk++;
         if (obs !== m_exp()) begin
            n_fail++; $display("FAIL random[%0d]: got %h expected %h", c, obs, m_exp());
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      m_reset();
      test_reset();
      test_basic();
      test_round_robin();
      test_abort();
      test_timeout();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
